fork_join_sched: RTL and testbench
==================================

FORK_JOIN_SCHED -- requirements
Module: fork_join_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each task duration.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: launch request, sampled only in IDLE.
REQ-005 SHALL have port mode, input, 2 bits: join mode, where 00=JOIN_ALL, 01=JOIN_ANY, 10=JOIN_NONE and 11 is reserved.
REQ-006 SHALL have ports dur_a, dur_b and dur_c, each input, CNT_W bits: cycle durations of tasks A, B and C.
REQ-007 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-008 SHALL have ports done_a, done_b and done_c, each output, 1 bit: one-cycle completion pulse per task.
REQ-009 SHALL have port join_evt, output, 1 bit: one-cycle pulse in the cycle task C is launched.
REQ-010 SHALL have port all_done, output, 1 bit: one-cycle pulse in the cycle the last task completes.
REQ-011 SHALL have port elapsed, output, CNT_W+2 bits: cycles since run acceptance.

Function
REQ-012 SHALL, on the edge where start=1 in IDLE (edge 0), latch mode, dur_a, dur_b and dur_c, set elapsed=0, and enter RUN_FORK.
REQ-013 SHALL number cycles k from the cycle following edge 0 (k=0); elapsed SHALL equal k in every busy cycle.
REQ-014 SHALL treat any latched duration of 0 as 1.
REQ-015 SHALL launch tasks A and B at k=0 and pulse done_a at k=dA and done_b at k=dB.
REQ-016 SHALL compute the C launch cycle L as follows: JOIN_ALL gives L=max(dA,dB); JOIN_ANY gives L=min(dA,dB); JOIN_NONE gives L=0.
REQ-017 SHALL treat mode 11 as JOIN_ALL.
REQ-018 SHALL pulse join_evt exactly once per run, at k=L, including when dA==dB.
REQ-019 SHALL pulse done_c at k=L+dC.
REQ-020 SHALL pulse all_done at k=T, where T=max(dA,dB,L+dC), coincident with the final done pulse(s).
REQ-021 SHALL use these states and transitions: IDLE->RUN_FORK on start; RUN_FORK->RUN_JOIN at k=L; RUN_JOIN->IDLE at k=T.
REQ-022 SHALL take the JOIN_NONE transition RUN_FORK->RUN_JOIN on the first busy cycle (k=0).
REQ-023 SHALL assert busy for k=0..T and deassert it at k=T+1.
REQ-024 SHALL accept a start at k=T+1 as a new run.
REQ-025 SHALL ignore start while busy, with no effect on the current run.
REQ-026 SHALL ignore changes to mode and dur_* after edge 0 until the next accepted start.
REQ-027 SHALL assert multiple done pulses in the same cycle when task completions coincide.
REQ-028 SHALL produce every pulse output from registered logic, glitch-free.
REQ-029 SHALL size elapsed so that it cannot wrap, since T <= 2*(2^CNT_W-1) < 2^(CNT_W+2).

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, busy=0, done_a=done_b=done_c=0, join_evt=0, all_done=0 and elapsed=0.
REQ-031 SHALL give rst priority over start in the same cycle.
REQ-032 SHALL, on rst mid-run, abort the run with no further pulses and be idle on the cycle after rst falls.

Verification
REQ-033 SHALL pass: dA=1000, dB=2000, dC=500, JOIN_ALL -> done_a@1000, join_evt@2000, done_b@2000, done_c@2500, all_done@2500, busy low @2501.
REQ-034 SHALL pass: same durations, JOIN_ANY -> done_a@1000, join_evt@1000, done_c@1500, done_b@2000, all_done@2000.
REQ-035 SHALL pass: same durations, JOIN_NONE -> join_evt@0, done_c@500, done_a@1000, done_b@2000, all_done@2000.
REQ-036 SHALL pass: dA=dB=4, dC=0, JOIN_ANY -> done_a, done_b and join_evt all @4; done_c and all_done @5; single join_evt only.
REQ-037 SHALL pass: start re-pulsed @k=3 in a run with dA=dB=dC=10 (JOIN_ALL) -> no effect, all_done@20; start @k=21 is accepted.
REQ-038 SHALL pass: rst asserted @k=7 of a JOIN_ALL run with dA=dB=dC=10 -> all outputs 0 the next cycle, no done_* pulses, idle after rst release.

Source files
------------

// File: rtl/fork_join_sched_if.sv
// Bus bundle for fork_join_sched: launch request, task durations and the
// registered status/pulse outputs. The master drives requests, the slave
// (the scheduler) drives status.
interface fork_join_sched_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] dur_a;
    logic [CNT_W-1:0] dur_b;
    logic [CNT_W-1:0] dur_c;
    logic             busy;
    logic             done_a;
    logic             done_b;
    logic             done_c;
    logic             join_evt;
    logic             all_done;
    logic [CNT_W+1:0] elapsed;

    modport master (
        output start, mode, dur_a, dur_b, dur_c,
        input  busy, done_a, done_b, done_c, join_evt, all_done, elapsed
    );

    modport slave (
        input  start, mode, dur_a, dur_b, dur_c,
        output busy, done_a, done_b, done_c, join_evt, all_done, elapsed
    );
endinterface

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: on start, tasks A and B run in parallel from k=0;
// task C launches at a join point chosen by mode (all/any/none). Every
// event cycle (launch, completions, end of run) is precomputed once at
// acceptance, so the run itself is just a cycle counter compared against
// fixed targets. All outputs come straight from flops.
module fork_join_sched #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fork_join_sched_if.slave      bus
);
    // Internal arithmetic is done at elapsed width so L+dC never overflows.
    localparam int E_W = CNT_W + 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN_FORK = 2'd1;
    localparam logic [1:0] ST_RUN_JOIN = 2'd2;

    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;

    localparam logic [E_W-1:0] ZERO_E = {E_W{1'b0}};
    localparam logic [E_W-1:0] ONE_E  = {{(E_W-1){1'b0}}, 1'b1};

    // A zero duration is treated as a one-cycle task.
    function automatic logic [E_W-1:0] norm_dur(input logic [CNT_W-1:0] d);
        logic [E_W-1:0] r;
        if (d == {CNT_W{1'b0}}) begin
            r = ONE_E;
        end else begin
            r = {2'b00, d};
        end
        return r;
    endfunction

    logic [1:0]     state_q,   state_d;
    logic [E_W-1:0] elapsed_q, elapsed_d;
    logic [E_W-1:0] da_q,      da_d;
    logic [E_W-1:0] db_q,      db_d;
    logic [E_W-1:0] l_q,       l_d;
    logic [E_W-1:0] cend_q,    cend_d;
    logic [E_W-1:0] t_q,       t_d;
    logic           busy_q,    busy_d;
    logic           done_a_q,  done_a_d;
    logic           done_b_q,  done_b_d;
    logic           done_c_q,  done_c_d;
    logic           join_q,    join_d;
    logic           all_q,     all_d;

    logic [E_W-1:0] na_s, nb_s, nc_s;
    logic [E_W-1:0] max_ab_s, min_ab_s;
    logic [E_W-1:0] launch_s, cend_s, total_s;
    logic [E_W-1:0] k_next_s;

    // Event schedule derived from the live inputs, used only at acceptance.
    always_comb begin
        na_s     = norm_dur(bus.dur_a);
        nb_s     = norm_dur(bus.dur_b);
        nc_s     = norm_dur(bus.dur_c);
        max_ab_s = (na_s > nb_s) ? na_s : nb_s;
        min_ab_s = (na_s < nb_s) ? na_s : nb_s;
        case (bus.mode)
            MODE_ANY:  launch_s = min_ab_s;
            MODE_NONE: launch_s = ZERO_E;
            default:   launch_s = max_ab_s;   // JOIN_ALL and reserved 11
        endcase
        cend_s   = launch_s + nc_s;
        total_s  = (cend_s > max_ab_s) ? cend_s : max_ab_s;
    end

    // Next state, counter and one-cycle pulse decode.
    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        da_d      = da_q;
        db_d      = db_q;
        l_d       = l_q;
        cend_d    = cend_q;
        t_d       = t_q;
        busy_d    = busy_q;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        done_c_d  = 1'b0;
        join_d    = 1'b0;
        all_d     = 1'b0;
        k_next_s  = elapsed_q + ONE_E;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_RUN_FORK;
                    elapsed_d = ZERO_E;
                    da_d      = na_s;
                    db_d      = nb_s;
                    l_d       = launch_s;
                    cend_d    = cend_s;
                    t_d       = total_s;
                    busy_d    = 1'b1;
                    // JOIN_NONE launches C in the very first busy cycle.
                    join_d    = (launch_s == ZERO_E);
                end else begin
                    busy_d    = 1'b0;
                end
            end
            ST_RUN_FORK, ST_RUN_JOIN: begin
                if (elapsed_q == t_q) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    elapsed_d = ZERO_E;
                end else begin
                    elapsed_d = k_next_s;
                    done_a_d  = (k_next_s == da_q);
                    done_b_d  = (k_next_s == db_q);
                    done_c_d  = (k_next_s == cend_q);
                    // k_next is never 0, so a JOIN_NONE run cannot pulse twice.
                    join_d    = (k_next_s == l_q);
                    all_d     = (k_next_s == t_q);
                    if ((state_q == ST_RUN_FORK) && (elapsed_q == l_q)) begin
                        state_d = ST_RUN_JOIN;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            elapsed_q <= ZERO_E;
            da_q      <= ZERO_E;
            db_q      <= ZERO_E;
            l_q       <= ZERO_E;
            cend_q    <= ZERO_E;
            t_q       <= ZERO_E;
            busy_q    <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            done_c_q  <= 1'b0;
            join_q    <= 1'b0;
            all_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            da_q      <= da_d;
            db_q      <= db_d;
            l_q       <= l_d;
            cend_q    <= cend_d;
            t_q       <= t_d;
            busy_q    <= busy_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            done_c_q  <= done_c_d;
            join_q    <= join_d;
            all_q     <= all_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done_a   = done_a_q;
    assign bus.done_b   = done_b_q;
    assign bus.done_c   = done_c_q;
    assign bus.join_evt = join_q;
    assign bus.all_done = all_q;
    assign bus.elapsed  = elapsed_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Self-checking bench for fork_join_sched: directed vector table, a few
// hand-written multi-cycle sequences, and randomized runs checked against
// an event-time model computed from the scheduling rules.
module tb_fork_join_sched;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fork_join_sched_if #(.CNT_W(CNT_W)) bus ();

    fork_join_sched #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         da, db, dc;
        int         ea, eb, el, ec, et;   // expected event cycles
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk6(input string name, input int k, input logic [5:0] exp6);
        logic [5:0] act;
        act = {bus.busy, bus.done_a, bus.done_b, bus.done_c, bus.join_evt, bus.all_done};
        checks++;
        if (act !== exp6) begin
            failures++;
            $display("FAIL %s k=%0d {busy,da,db,dc,join,all} got=%b want=%b", name, k, act, exp6);
        end
    endtask

    task automatic chk_el(input string name, input int k, input int exp_el);
        checks++;
        if (bus.elapsed !== exp_el[CNT_W+1:0]) begin
            failures++;
            $display("FAIL %s k=%0d elapsed got=%0d want=%0d", name, k, bus.elapsed, exp_el);
        end
    endtask

    // Expected event cycles from the scheduling rules.
    function automatic vec_t model(input logic [1:0] m, input int da, input int db, input int dc);
        vec_t v;
        int a, b, c, l;
        a = (da == 0) ? 1 : da;
        b = (db == 0) ? 1 : db;
        c = (dc == 0) ? 1 : dc;
        if (m == 2'b01)      l = (a < b) ? a : b;
        else if (m == 2'b10) l = 0;
        else                 l = (a > b) ? a : b;
        v.mode = m; v.da = da; v.db = db; v.dc = dc;
        v.ea = a; v.eb = b; v.el = l; v.ec = l + c;
        v.et = (a > b) ? a : b;
        if (l + c > v.et) v.et = l + c;
        return v;
    endfunction

    // Launch one run from idle and check every cycle k=0..T+1.
    // noisy: scramble inputs (start included) while busy.
    // pulse_k: force a start pulse at that busy cycle (-1 for none).
    // adv_last: if 0, stay in cycle T+1 so the caller can start there.
    task automatic run_check(input string name, input vec_t v, input bit noisy,
                             input int pulse_k, input bit adv_last);
        logic [5:0] e;
        bus.mode  = v.mode;
        bus.dur_a = v.da[CNT_W-1:0];
        bus.dur_b = v.db[CNT_W-1:0];
        bus.dur_c = v.dc[CNT_W-1:0];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= v.et + 1; k++) begin
            e = {(k <= v.et), (k == v.ea), (k == v.eb), (k == v.ec), (k == v.el), (k == v.et)};
            chk6(name, k, e);
            if (k <= v.et) chk_el(name, k, k);
            if (noisy && k <= v.et) begin
                bus.mode  = 2'($urandom_range(0, 3));
                bus.dur_a = CNT_W'($urandom_range(0, 9));
                bus.dur_b = CNT_W'($urandom_range(0, 9));
                bus.dur_c = CNT_W'($urandom_range(0, 9));
                bus.start = 1'($urandom_range(0, 1));
            end else begin
                bus.start = 1'b0;
            end
            if (k == pulse_k) bus.start = 1'b1;
            if (k == v.et + 1 && !adv_last) break;
            tick();
            bus.start = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        checks = 0;
        failures = 0;
        vecs[0] = '{2'b00, 1000, 2000, 500, 1000, 2000, 2000, 2500, 2500};
        vecs[1] = '{2'b01, 1000, 2000, 500, 1000, 2000, 1000, 1500, 2000};
        vecs[2] = '{2'b10, 1000, 2000, 500, 1000, 2000,    0,  500, 2000};
        vecs[3] = '{2'b01,    4,    4,   0,    4,    4,    4,    5,    5};
        vecs[4] = '{2'b00,    0,    0,   0,    1,    1,    1,    2,    2};
        vecs[5] = '{2'b10,    3,    7,  20,    3,    7,    0,   20,   20};
        vecs[6] = '{2'b11,    5,    2,   3,    5,    2,    5,    8,    8};
        vecs[7] = '{2'b01,    9,    2,   3,    9,    2,    2,    5,    9};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.dur_a = '0;
        bus.dur_b = '0;
        bus.dur_c = '0;
        tick();
        tick();
        chk6("reset", 0, 6'b000000);
        chk_el("reset", 0, 0);
        rst = 1'b0;
        tick();
        chk6("idle_after_reset", 0, 6'b000000);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i], 1'b0, -1, 1'b1);
        end

        // Start re-pulsed mid-run is ignored; start at k=T+1 is accepted.
        v = '{2'b00, 10, 10, 10, 10, 10, 10, 20, 20};
        run_check("restart_ignored", v, 1'b0, 3, 1'b0);
        v = model(2'b01, 6, 3, 2);
        run_check("start_at_T+1", v, 1'b0, -1, 1'b1);

        // Reset mid-run at k=7 aborts with no further pulses.
        bus.mode = 2'b00; bus.dur_a = 16'd10; bus.dur_b = 16'd10; bus.dur_c = 16'd10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            chk6("pre_abort", k, 6'b100000);
            chk_el("pre_abort", k, k);
            if (k < 7) tick();
        end
        rst = 1'b1;
        tick();
        chk6("abort", 8, 6'b000000);
        chk_el("abort", 8, 0);
        bus.start = 1'b1;             // reset wins over start
        tick();
        chk6("rst_over_start", 9, 6'b000000);
        rst = 1'b0;
        bus.start = 1'b0;
        for (int k = 10; k < 25; k++) begin
            tick();
            chk6("post_abort_idle", k, 6'b000000);
        end

        // Randomized runs with input noise while busy.
        for (int r = 0; r < 40; r++) begin
            v = model(2'($urandom_range(0, 3)), int'($urandom_range(0, 30)),
                      int'($urandom_range(0, 30)), int'($urandom_range(0, 30)));
            run_check($sformatf("rand%0d", r), v, 1'b1, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
